// File: rtl/burst_gen_pkg.sv
// Shared definitions for the burst sequencer: FSM states, AHB HTRANS and
// transfer-size codes, burst lengths, and the start-address helpers.
package burst_gen_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ISSUE,
        S_RUN,
        S_NEXT,
        S_FIN
    } state_t;

    typedef enum logic [1:0] {
        HT_IDLE = 2'd0,
        HT_BUSY = 2'd1,
        HT_NSEQ = 2'd2,
        HT_SEQ  = 2'd3
    } htrans_t;

    typedef enum logic [1:0] {
        SZ_B8  = 2'd0,
        SZ_B16 = 2'd1,
        SZ_B32 = 2'd2
    } size_t;

    localparam logic [4:0] BL_SINGLE = 5'd1;
    localparam logic [4:0] BL_INCR4  = 5'd4;
    localparam logic [4:0] BL_INCR8  = 5'd8;
    localparam logic [4:0] BL_INCR16 = 5'd16;

    // Any size code above word is handled as a word transfer.
    function automatic size_t norm_size(input logic [2:0] size);
        case (size)
            3'd0:    return SZ_B8;
            3'd1:    return SZ_B16;
            default: return SZ_B32;
        endcase
    endfunction

    // Round the start address up to the next multiple of the transfer size;
    // the add wraps modulo 2^32 near the top of the address space.
    function automatic logic [31:0] align_addr(input logic [31:0] addr, input size_t size);
        case (size)
            SZ_B16:  return (addr + 32'd1) & ~32'd1;
            SZ_B32:  return (addr + 32'd3) & ~32'd3;
            default: return addr;
        endcase
    endfunction

endpackage

// File: rtl/burst_len_calc.sv
// Picks the beat count of the next burst: the largest of 16/8/4 that fits
// both the remaining beats and the distance to the next boundary, else 1.
module burst_len_calc
    import burst_gen_pkg::*;
#(
    parameter int LEN_W    = 16,
    parameter int BOUNDARY = 1024
) (
    input  logic [31:0]      addr,
    input  logic [LEN_W-1:0] rem,
    input  size_t            size,
    output logic [4:0]       count
);

    localparam int OFF_W = $clog2(BOUNDARY);

    logic [31:0] bnd;
    logic [31:0] lim;

    // Beats left before the boundary, clipped to the remaining beat count.
    always_comb begin
        // NOTE: every variable gets a default first so no path can leave it unassigned (no latch).
        bnd   = 32'd0;
        lim   = 32'd0;
        count = BL_SINGLE;
        bnd = (32'(BOUNDARY) - {{(32-OFF_W){1'b0}}, addr[OFF_W-1:0]}) >> size;
        lim = (32'(rem) < bnd) ? 32'(rem) : bnd;
        if (lim >= 32'(BL_INCR16))
            count = BL_INCR16;
        else if (lim >= 32'(BL_INCR8))
            count = BL_INCR8;
        else if (lim >= 32'(BL_INCR4))
            count = BL_INCR4;
        else
            count = BL_SINGLE;
    end

endmodule

// File: rtl/burst_gen.sv
// Block-transfer sequencer for the AHB master: splits a transfer into
// boundary-safe bursts, issues each one, and tracks completion from the bus.
module burst_gen
    import burst_gen_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 16,
    parameter int BOUNDARY   = 1024
) (
    input  logic             I_BGEN_HCLK,
    input  logic             I_BGEN_HRESET,
    input  logic             I_BGEN_START,
    input  logic [31:0]      I_BGEN_ADDR,
    input  logic [LEN_W-1:0] I_BGEN_LEN,
    input  logic [2:0]       I_BGEN_SIZE,
    input  logic             I_BGEN_WRITE,
    input  logic [4:0]       I_BGEN_FIFO_LVL,
    input  logic [1:0]       I_BGEN_HTRANS,
    input  logic             I_BGEN_HREADY,
    output logic [31:0]      O_BGEN_ADDR,
    output logic [4:0]       O_BGEN_COUNT,
    output logic             O_BGEN_WRITE,
    output logic             O_BGEN_BSTART,
    output logic             O_BGEN_BUSY,
    output logic             O_BGEN_ACTIVE,
    output logic             O_BGEN_DONE
);

    state_t           state;
    logic [31:0]      addr_q;
    logic [LEN_W-1:0] rem_q;
    size_t            size_q;
    logic [4:0]       beat_acc;
    logic [4:0]       calc_count;
    size_t            start_size;
    htrans_t          htrans;
    logic             beat;

    assign start_size = norm_size(I_BGEN_SIZE);
    assign htrans     = htrans_t'(I_BGEN_HTRANS);
    assign beat       = I_BGEN_HREADY && (htrans == HT_NSEQ || htrans == HT_SEQ);

    burst_len_calc #(
        .LEN_W    (LEN_W),
        .BOUNDARY (BOUNDARY)
    ) u_len_calc (
        .addr  (addr_q),
        .rem   (rem_q),
        .size  (size_q),
        .count (calc_count)
    );

    // Sequencer FSM with registered burst outputs and completion pulse.
    always_ff @(posedge I_BGEN_HCLK) begin
        if (I_BGEN_HRESET) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state         <= S_IDLE;
            addr_q        <= '0;
            rem_q         <= '0;
            size_q        <= SZ_B8;
            beat_acc      <= '0;
            O_BGEN_ADDR   <= '0;
            O_BGEN_COUNT  <= '0;
            O_BGEN_WRITE  <= 1'b0;
            O_BGEN_BSTART <= 1'b0;
            O_BGEN_ACTIVE <= 1'b0;
            O_BGEN_DONE   <= 1'b0;
        end else begin
            O_BGEN_BSTART <= 1'b0;
            O_BGEN_DONE   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (I_BGEN_START) begin
                        addr_q        <= align_addr(I_BGEN_ADDR, start_size);
                        size_q        <= start_size;
                        rem_q         <= I_BGEN_LEN;
                        O_BGEN_WRITE  <= I_BGEN_WRITE;
                        O_BGEN_ACTIVE <= 1'b1;
                        state         <= (I_BGEN_LEN == '0) ? S_FIN : S_CALC;
                    end
                end
                S_CALC: begin
                    O_BGEN_ADDR   <= addr_q;
                    O_BGEN_COUNT  <= calc_count;
                    O_BGEN_BSTART <= 1'b1;
                    beat_acc      <= '0;
                    state         <= S_ISSUE;
                end
                S_ISSUE: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    // Once all beats are counted, the next ready cycle closes the last data phase.
                    if (beat_acc == O_BGEN_COUNT) begin
                        if (I_BGEN_HREADY) begin
                            rem_q  <= rem_q - LEN_W'(O_BGEN_COUNT);
                            addr_q <= addr_q + (32'(O_BGEN_COUNT) << size_q);
                            state  <= S_NEXT;
                        end
                    end else if (beat) begin
                        beat_acc <= beat_acc + 5'd1;
                    end
                end
                S_NEXT: begin
                    state <= (rem_q == '0) ? S_FIN : S_CALC;
                end
                S_FIN: begin
                    O_BGEN_DONE   <= 1'b1;
                    O_BGEN_ACTIVE <= 1'b0;
                    state         <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO stall flag toward the bus interface, meaningful only while a burst runs.
    always_comb begin
        O_BGEN_BUSY = 1'b0;
        if (state == S_RUN) begin
            if (O_BGEN_WRITE)
                O_BGEN_BUSY = (I_BGEN_FIFO_LVL == 5'd0);
            else
                O_BGEN_BUSY = ({27'd0, I_BGEN_FIFO_LVL} >= 32'(FIFO_DEPTH - 1));
        end
    end

endmodule

// File: tb/tb_burst_gen.sv
// Directed bench for burst_gen: runs hand-computed transfers and compares
// burst addresses/counts, DONE latency, BUSY cycles, ACTIVE and reset behaviour.
module tb_burst_gen;

    logic        clk;
    logic        hrst;
    logic        start_i;
    logic [31:0] addr_i;
    logic [15:0] len_i;
    logic [2:0]  size_i;
    logic        write_i;
    logic [4:0]  fifo_lvl;
    logic [1:0]  htrans;
    logic        hready;
    logic [31:0] o_addr;
    logic [4:0]  o_count;
    logic        o_write;
    logic        bstart;
    logic        busy;
    logic        active;
    logic        done;

    int          total;
    int          bad;

    // Observations gathered by run_xfer.
    int          done_cyc;
    int          n_bs;
    logic [31:0] bs_addr [8];
    logic [4:0]  bs_cnt  [8];
    int          busy_cnt;
    int          active_bad;
    logic [1:0]  post_done;
    logic        last_wr;
    logic [31:0] rst_addr;
    logic [10:0] rst_flags;

    burst_gen #(
        .FIFO_DEPTH (16),
        .LEN_W      (16),
        .BOUNDARY   (1024)
    ) dut (
        .I_BGEN_HCLK     (clk),
        .I_BGEN_HRESET   (hrst),
        .I_BGEN_START    (start_i),
        .I_BGEN_ADDR     (addr_i),
        .I_BGEN_LEN      (len_i),
        .I_BGEN_SIZE     (size_i),
        .I_BGEN_WRITE    (write_i),
        .I_BGEN_FIFO_LVL (fifo_lvl),
        .I_BGEN_HTRANS   (htrans),
        .I_BGEN_HREADY   (hready),
        .O_BGEN_ADDR     (o_addr),
        .O_BGEN_COUNT    (o_count),
        .O_BGEN_WRITE    (o_write),
        .O_BGEN_BSTART   (bstart),
        .O_BGEN_BUSY     (busy),
        .O_BGEN_ACTIVE   (active),
        .O_BGEN_DONE     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transfer: START in cycle 0, then observe cycles 1..budget at negedge.
    // stall_at starts a 5-cycle window of LVL=0 with HTRANS=BUSY; restart_at
    // pulses a second START; rst_at pulses HRESET (-1 disables each).
    task automatic run_xfer(input logic [31:0] a, input logic [15:0] len, input logic [2:0] sz,
                            input logic wr, input logic [4:0] lvl, input int stall_at,
                            input int restart_at, input int rst_at, input int budget);
        done_cyc   = -1;
        n_bs       = 0;
        busy_cnt   = 0;
        active_bad = 0;
        last_wr    = 1'b0;
        rst_addr   = 32'hffff_ffff;
        rst_flags  = '1;
        @(negedge clk);
        start_i  = 1'b1;
        addr_i   = a;
        len_i    = len;
        size_i   = sz;
        write_i  = wr;
        fifo_lvl = lvl;
        htrans   = 2'd3;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (bstart) begin
                if (n_bs < 8) begin
                    bs_addr[n_bs] = o_addr;
                    bs_cnt[n_bs]  = o_count;
                end
                n_bs++;
            end
            if (busy)
                busy_cnt++;
            if (k == rst_at + 1) begin
                rst_addr  = o_addr;
                rst_flags = {o_count, o_write, bstart, busy, active, done, 1'b0};
            end
            if (done) begin
                done_cyc = k;
                if (active)
                    active_bad++;
                break;
            end
            if (active != !(rst_at >= 0 && k > rst_at))
                active_bad++;
            if (active)
                last_wr = o_write;
            hrst = (k == rst_at);
            if (k == restart_at) begin
                start_i = 1'b1;
                addr_i  = 32'h200;
                len_i   = 16'd4;
                write_i = ~wr;
            end
            if (stall_at > 0 && k >= stall_at && k < stall_at + 5) begin
                fifo_lvl = 5'd0;
                htrans   = 2'd1;
            end else begin
                fifo_lvl = lvl;
                htrans   = 2'd3;
            end
        end
        @(negedge clk);
        post_done = {done, active};
        hrst      = 1'b0;
        start_i   = 1'b0;
        htrans    = 2'd3;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        hrst     = 1'b1;
        start_i  = 1'b0;
        addr_i   = '0;
        len_i    = '0;
        size_i   = '0;
        write_i  = 1'b0;
        fifo_lvl = 5'd14;
        htrans   = 2'd3;
        hready   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_addr", o_addr, 32'h0);
        check("reset_flags", {25'd0, o_count, o_write, bstart, busy, active, done}, 32'h0);
        hrst = 1'b0;

        // 1) 40 words from 0: 16 + 16 + 8 beats, DONE at (20+20+12)+2.
        run_xfer(32'h000, 16'd40, 3'd2, 1'b0, 5'd14, -1, -1, -1, 80);
        check("t1_done_cyc", done_cyc, 54);
        check("t1_nbursts", n_bs, 3);
        check("t1_b0_addr", bs_addr[0], 32'h000);
        check("t1_b0_cnt", bs_cnt[0], 16);
        check("t1_b1_addr", bs_addr[1], 32'h040);
        check("t1_b1_cnt", bs_cnt[1], 16);
        check("t1_b2_addr", bs_addr[2], 32'h080);
        check("t1_b2_cnt", bs_cnt[2], 8);
        check("t1_busy_lvl14", busy_cnt, 0);
        check("t1_active", active_bad, 0);
        check("t1_one_done", post_done, 0);

        // 2) 0x3F0, 8 words: split at the 1 KB boundary into 4 + 4.
        run_xfer(32'h3F0, 16'd8, 3'd2, 1'b0, 5'd14, -1, -1, -1, 60);
        check("t2_done_cyc", done_cyc, 18);
        check("t2_nbursts", n_bs, 2);
        check("t2_b0_addr", bs_addr[0], 32'h3F0);
        check("t2_b0_cnt", bs_cnt[0], 4);
        check("t2_b1_addr", bs_addr[1], 32'h400);
        check("t2_b1_cnt", bs_cnt[1], 4);

        // 3) halfwords from 0x101 -> 0x102; singles; read LVL=15 stalls every RUN cycle.
        run_xfer(32'h101, 16'd3, 3'd1, 1'b0, 5'd15, -1, -1, -1, 60);
        check("t3_done_cyc", done_cyc, 17);
        check("t3_nbursts", n_bs, 3);
        check("t3_b0_addr", bs_addr[0], 32'h102);
        check("t3_b1_addr", bs_addr[1], 32'h104);
        check("t3_b2_addr", bs_addr[2], 32'h106);
        check("t3_b2_cnt", bs_cnt[2], 1);
        check("t3_busy_lvl15", busy_cnt, 6);

        // Size code 7 acts as word: 0x3F1 -> 0x3F4, one single.
        run_xfer(32'h3F1, 16'd1, 3'd7, 1'b0, 5'd14, -1, -1, -1, 40);
        check("t3b_done_cyc", done_cyc, 7);
        check("t3b_b0_addr", bs_addr[0], 32'h3F4);
        check("t3b_b0_cnt", bs_cnt[0], 1);

        // 4) write of 16 words with a 5-cycle empty-FIFO stall mid-burst.
        run_xfer(32'h000, 16'd16, 3'd2, 1'b1, 5'd8, 6, -1, -1, 80);
        check("t4_busy_cycles", busy_cnt, 5);
        check("t4_done_cyc", done_cyc, 27);
        check("t4_nbursts", n_bs, 1);
        check("t4_b0_cnt", bs_cnt[0], 16);
        check("t4_write", last_wr, 1);

        // 5) LEN=0: no burst, DONE two cycles after START.
        run_xfer(32'h080, 16'd0, 3'd2, 1'b0, 5'd14, -1, -1, -1, 20);
        check("t5_done_cyc", done_cyc, 2);
        check("t5_nbursts", n_bs, 0);
        check("t5_one_done", post_done, 0);

        // 5b) a second START while ACTIVE is ignored.
        run_xfer(32'h000, 16'd16, 3'd2, 1'b0, 5'd14, -1, 5, -1, 80);
        check("t5b_done_cyc", done_cyc, 22);
        check("t5b_nbursts", n_bs, 1);
        check("t5b_b0_addr", bs_addr[0], 32'h000);
        check("t5b_write", last_wr, 0);
        check("t5b_idle_after", post_done, 0);

        // 6) reset during RUN: outputs clear, no DONE; then a normal transfer.
        run_xfer(32'h080, 16'd16, 3'd2, 1'b1, 5'd8, -1, -1, 8, 40);
        check("t6_rst_addr", rst_addr, 32'h0);
        check("t6_rst_flags", {21'd0, rst_flags}, 32'h0);
        check("t6_no_done", done_cyc, 32'hffff_ffff);
        check("t6_active", active_bad, 0);
        run_xfer(32'h3F0, 16'd8, 3'd2, 1'b0, 5'd14, -1, -1, -1, 60);
        check("t6b_done_cyc", done_cyc, 18);
        check("t6b_b1_addr", bs_addr[1], 32'h400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
